seqdet_scheduler: RTL and testbench
===================================

SEQDET_SCHEDULER -- requirements
Module: seqdet_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters.
REQ-002 Parameter FRAME_W, default 8: bits per frame.
REQ-003 Parameter CNT_W, default 4: width of the match counter.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester frame request, level.
REQ-007 req_data  input  N_REQ*FRAME_W  frames; requester i occupies bits [i*FRAME_W +: FRAME_W].
REQ-008 ack  output  N_REQ  one-hot, single-cycle pulse; frame accepted.
REQ-009 det_clr  output  1  single-cycle clear to the sequence detector.
REQ-010 det_x  output  1  serial bit to the detector.
REQ-011 det_y  input  1  detector match flag; registered, so it reflects the det_x of the previous cycle.
REQ-012 done  output  1  single-cycle result strobe.
REQ-013 result_id  output  $clog2(N_REQ)  index of the served requester; valid with done.
REQ-014 result_cnt  output  CNT_W  matches in the frame; valid with done.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, SHIFT, DRAIN and REPORT.
REQ-017 IDLE: when any req bit is high, the round-robin winner SHALL be chosen, its frame latched, ack[winner] pulsed that cycle, and the FSM SHALL move to CLEAR; otherwise it SHALL stay in IDLE.
REQ-018 Round-robin: search order SHALL start at the requester after the last grant; after reset it SHALL start at requester 0.
REQ-019 CLEAR: det_clr SHALL be 1 for exactly one cycle; the bit index SHALL load FRAME_W-1; the match counter SHALL clear; next state SHALL be SHIFT.
REQ-020 SHIFT: det_x SHALL equal frame[index], MSB first, for FRAME_W consecutive cycles, then the FSM SHALL move to DRAIN.
REQ-021 det_y SHALL be sampled in SHIFT cycles 2..FRAME_W and in the DRAIN cycle, giving exactly FRAME_W samples.
REQ-022 Each sample with det_y=1 SHALL increment the counter.
REQ-023 The counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 DRAIN SHALL last one cycle and then move to REPORT.
REQ-025 REPORT: done=1 with result_id and result_cnt for one cycle, then the FSM SHALL return to IDLE.
REQ-026 Latency: the ack cycle to the done cycle SHALL be exactly FRAME_W+3 cycles (CLEAR 1, SHIFT FRAME_W, DRAIN 1, REPORT 1).
REQ-027 req SHALL be sampled only in IDLE; requests arriving while busy wait for IDLE.
REQ-028 Deasserting req after ack SHALL NOT affect the frame in flight.
REQ-029 det_x SHALL be 0 outside SHIFT.
REQ-030 Back-to-back: a req pending in the REPORT cycle SHALL be acked on the following IDLE cycle, giving one idle cycle between frames.

Reset
REQ-031 On reset=0, asynchronously:
- FSM SHALL go to IDLE.
- ack, det_clr, det_x, done, busy, result_id, result_cnt SHALL all be 0.
- Round-robin pointer SHALL be set so requester 0 has priority.
REQ-032 Reset mid-frame SHALL abandon the frame with no done; the requester must re-request.

Configuration
REQ-033 Macro SEQDET_HITPOS_EN, when defined, SHALL add output first_hit of width $clog2(FRAME_W+1), valid with done.
REQ-034 first_hit SHALL be the 1-based sample number of the first det_y=1, or 0 if the frame had no match.
REQ-035 Without SEQDET_HITPOS_EN the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-036 A shared package SHALL hold the FSM state enum and the default parameter constants.
REQ-037 The arbiter SHALL be one sub-module, seqdet_rr_arb (inputs req, enable; outputs one-hot grant, index); the FSM and shifter stay in the top level.

Verification
REQ-038 Bench SHALL model the detector as an overlapping 101010 detector with registered output. Directed scenarios:
- Single frame: req[0]=1, frame 8'b00101010 -> ack[0] pulse; done 11 cycles later; result_id=0, result_cnt=1.
- Overlap: frame 8'b10101010 on req[2] -> result_cnt=2, result_id=2.
- Zero matches: frame 8'h00 -> result_cnt=0; with SEQDET_HITPOS_EN, first_hit=0.
- Contention: req=4'b1111 held for 4 frames -> grant order 0,1,2,3; then 0 again.
- Reset mid-SHIFT: reset=0 in the 4th SHIFT cycle -> all outputs 0 immediately, no done; next request starts fresh from CLEAR.
- Saturation: CNT_W=1, frame 8'b10101010 -> result_cnt=1 (saturated, not wrapped to 0).

Source files
------------

// File: rtl/seqdet_scheduler_pkg.sv
// Shared types and default sizes for the sequence-detector scheduler.
// State encoding and parameter defaults used by the top and the arbiter.
package seqdet_scheduler_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int FRAME_W_DEF = 8;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        REPORT
    } state_t;

endpackage

// File: rtl/seqdet_scheduler_rr_arb.sv
// Round-robin arbiter: one-hot grant plus binary index.
// Priority starts at the requester after the last grant; requester 0 after reset.
module seqdet_rr_arb
    import seqdet_scheduler_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic                     enable,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] index
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] ptr_q;

    // Pick the first active requester at or after ptr_q, wrapping around
    always_comb begin
        int   j;
        logic found;
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr_q) + i) % N_REQ;
            if (enable && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end

    // Priority moves to the requester just after each winner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (|grant) begin
            ptr_q <= (index == IW'(N_REQ - 1)) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/seqdet_scheduler.sv
// Frame scheduler: arbitrates requesters, streams each frame MSB-first
// to a sequence detector and reports the match count. Option: SEQDET_HITPOS_EN.
module seqdet_scheduler
    import seqdet_scheduler_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       det_clr,
    output logic                       det_x,
    input  logic                       det_y,
    output logic                       done,
    output logic [$clog2(N_REQ)-1:0]   result_id,
    output logic [CNT_W-1:0]           result_cnt,
    output logic                       busy
`ifdef SEQDET_HITPOS_EN
    ,
    output logic [$clog2(FRAME_W+1)-1:0] first_hit
`endif
);

    localparam int IDW = $clog2(N_REQ);
    localparam int IXW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [N_REQ-1:0]   grant;
    logic [IDW-1:0]     win;
    logic               arb_en;
    logic [FRAME_W-1:0] frame_q;
    logic [IXW-1:0]     idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDW-1:0]     id_q;
    logic               sample;
    logic               hit;

    // Arbitration only runs in IDLE and never while reset is held
    assign arb_en = (state_q == IDLE) && reset;

    seqdet_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .enable (arb_en),
        .grant  (grant),
        .index  (win)
    );

    assign ack        = grant;
    assign result_id  = id_q;
    assign result_cnt = cnt_q;

    // det_y lags det_x by one cycle, so skip SHIFT cycle 1 and take DRAIN
    assign sample = ((state_q == SHIFT) && (idx_q != IXW'(FRAME_W - 1)))
                  || (state_q == DRAIN);
    assign hit    = sample && det_y;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        det_clr = 1'b0;
        det_x   = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (|grant) state_d = CLEAR;
            end
            CLEAR: begin
                det_clr = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                det_x = frame_q[idx_q];
                if (idx_q == '0) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = REPORT;
            end
            REPORT: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame capture, bit index and saturating match counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            if ((state_q == IDLE) && (|grant)) begin
                frame_q <= req_data[win*FRAME_W +: FRAME_W];
                id_q    <= win;
            end
            if (state_q == CLEAR) begin
                idx_q <= IXW'(FRAME_W - 1);
                cnt_q <= '0;
            end else begin
                if (state_q == SHIFT) idx_q <= idx_q - 1'b1;
                if (hit && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SEQDET_HITPOS_EN
    localparam int HPW = $clog2(FRAME_W + 1);

    logic [HPW-1:0] hit_q;
    logic [HPW-1:0] snum;

    assign first_hit = hit_q;
    assign snum = (state_q == DRAIN) ? HPW'(FRAME_W)
                : HPW'(FRAME_W - 1) - HPW'(idx_q);

    // Remember the 1-based sample number of the first match
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q <= '0;
        end else if (state_q == CLEAR) begin
            hit_q <= '0;
        end else if (hit && (hit_q == '0)) begin
            hit_q <= snum;
        end
    end
`endif

endmodule

// File: tb/tb_seqdet_scheduler.sv
// Self-checking bench for seqdet_scheduler with a 101010 detector model.
// Runs a default instance and a CNT_W=1 instance for saturation.
module tb_seqdet_scheduler;

    localparam int N  = 4;
    localparam int FW = 8;
    localparam int CW = 4;

    localparam logic [7:0] FA = 8'h2A;
    localparam logic [7:0] FB = 8'hAA;
    localparam logic [7:0] FC = 8'h00;
    localparam logic [7:0] FD = 8'h54;
    localparam logic [7:0] FE = 8'hFF;
    localparam logic [7:0] FF = 8'hAB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*FW-1:0] req_data = '0;

    logic [N-1:0]  ack0, ack1;
    logic          clr0, clr1, x0, x1, done0, done1, busy0, busy1;
    logic          y0, y1;
    logic [1:0]    id0, id1;
    logic [CW-1:0] cnt0;
    logic [0:0]    cnt1;
`ifdef SEQDET_HITPOS_EN
    logic [3:0]    hit0, hit1;
`endif

    always #5 clk = ~clk;

    seqdet_scheduler #(.N_REQ(N), .FRAME_W(FW), .CNT_W(CW)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack0),
        .det_clr    (clr0),
        .det_x      (x0),
        .det_y      (y0),
        .done       (done0),
        .result_id  (id0),
        .result_cnt (cnt0),
        .busy       (busy0)
`ifdef SEQDET_HITPOS_EN
        ,
        .first_hit  (hit0)
`endif
    );

    seqdet_scheduler #(.N_REQ(N), .FRAME_W(FW), .CNT_W(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack1),
        .det_clr    (clr1),
        .det_x      (x1),
        .det_y      (y1),
        .done       (done1),
        .result_id  (id1),
        .result_cnt (cnt1),
        .busy       (busy1)
`ifdef SEQDET_HITPOS_EN
        ,
        .first_hit  (hit1)
`endif
    );

    // Overlapping 101010 detectors with registered match flags
    logic [5:0] sh0, sh1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh0 <= '0;
            y0  <= 1'b0;
        end else if (clr0) begin
            sh0 <= '0;
            y0  <= 1'b0;
        end else begin
            sh0 <= {sh0[4:0], x0};
            y0  <= ({sh0[4:0], x0} == 6'b101010);
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh1 <= '0;
            y1  <= 1'b0;
        end else if (clr1) begin
            sh1 <= '0;
            y1  <= 1'b0;
        end else begin
            sh1 <= {sh1[4:0], x1};
            y1  <= ({sh1[4:0], x1} == 6'b101010);
        end
    end

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] data;
        int          id;
        int          cnt;
        int          hit;
    } vec_t;

    typedef struct {
        int id;
        int cnt;
        int hit;
    } exp_t;

    exp_t resq[$];
    int   ackq[$];
    int   latq[$];
    vec_t tbl[7];

    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   last_done = -1;
    bit   b2b = 1'b0;
    int   m_id;
    exp_t m_r;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ack"}, 32'(ack0), 0);
        chk({tag, "_clr"}, 32'(clr0), 0);
        chk({tag, "_x"}, 32'(x0), 0);
        chk({tag, "_done"}, 32'(done0), 0);
        chk({tag, "_busy"}, 32'(busy0), 0);
        chk({tag, "_id"}, 32'(id0), 0);
        chk({tag, "_cnt"}, 32'(cnt0), 0);
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack0 == '0 && n < 40);
        if (ack0 == '0) begin
            nvec++;
            nerr++;
            $display("FAIL %s_ack_timeout: got no ack, expected ack within 40", tag);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 40);
        if (!done0) begin
            nvec++;
            nerr++;
            $display("FAIL %s_done_timeout: got no done, expected done within 40", tag);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop expectations as acks and results appear
    always @(negedge clk) begin
        if (ack0 != '0) begin
            if (ackq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL ack_unexpected: got %b, expected 0", ack0);
            end else begin
                m_id = ackq.pop_front();
                chk("ack_onehot", 32'(ack0), 32'(1) << m_id);
                latq.push_back(cyc);
                if (b2b && last_done >= 0)
                    chk("b2b_gap", cyc - last_done, 1);
            end
        end
        if (done0) begin
            if (resq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL done_unexpected: got done=1, expected 0");
            end else begin
                m_r = resq.pop_front();
                chk("result_id", 32'(id0), m_r.id);
                chk("result_cnt", 32'(cnt0), m_r.cnt);
`ifdef SEQDET_HITPOS_EN
                chk("first_hit", 32'(hit0), m_r.hit);
`endif
                chk("sat_done", 32'(done1), 1);
                chk("sat_cnt", 32'(cnt1), (m_r.cnt > 0) ? 1 : 0);
                if (latq.size() > 0)
                    chk("latency", cyc - latq.pop_front(), FW + 3);
            end
            last_done = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0001, {FE, FE, FE, FA}, 0, 1, 8};
        tbl[1] = '{4'b0100, {FE, FB, FE, FE}, 2, 2, 6};
        tbl[2] = '{4'b0010, {FE, FE, FC, FE}, 1, 0, 0};
        tbl[3] = '{4'b1001, {FD, FE, FE, FF}, 3, 1, 7};
        tbl[4] = '{4'b1001, {FD, FE, FE, FF}, 0, 1, 6};
        tbl[5] = '{4'b1111, {FA, FB, FC, FD}, 1, 0, 0};
        tbl[6] = '{4'b1011, {FA, FB, FC, FD}, 3, 1, 8};

        req = 4'b1111;
        #1;
        chk_idle("rst");
        req = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        foreach (tbl[k]) begin
            @(posedge clk);
            #1;
            req      = tbl[k].rq;
            req_data = tbl[k].data;
            ackq.push_back(tbl[k].id);
            resq.push_back('{tbl[k].id, tbl[k].cnt, tbl[k].hit});
            wait_ack("tbl");
            @(posedge clk);
            #1;
            req      = '0;
            req_data = $urandom;
            wait_done("tbl");
        end

        // Contention: all four held, order 0,1,2,3,0 with one idle gap
        @(posedge clk);
        #1 reset = 1'b0;
        req      = 4'b1111;
        req_data = {FA, FB, FC, FD};
        #1;
        chk_idle("rst2");
        ackq.push_back(0); resq.push_back('{0, 1, 7});
        ackq.push_back(1); resq.push_back('{1, 0, 0});
        ackq.push_back(2); resq.push_back('{2, 2, 6});
        ackq.push_back(3); resq.push_back('{3, 1, 8});
        ackq.push_back(0); resq.push_back('{0, 1, 7});
        latq.delete();
        b2b = 1'b1;
        last_done = -1;
        @(posedge clk);
        #1 reset = 1'b1;
        begin
            int nd = 0;
            int t = 0;
            while (nd < 5 && t < 120) begin
                @(negedge clk);
                t++;
                if (done0) nd++;
                if (nd == 5) req = '0;
            end
            chk("contention_frames", nd, 5);
        end
        b2b = 1'b0;

        // Reset in the 4th SHIFT cycle abandons the frame
        @(posedge clk);
        #1;
        req      = 4'b0100;
        req_data = {FE, FB, FE, FE};
        ackq.push_back(2);
        wait_ack("mid");
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(busy0), 1);
        chk("mid_id", 32'(id0), 2);
        reset = 1'b0;
        #1;
        chk_idle("mid_rst");
        latq.delete();
        ackq.push_back(2);
        resq.push_back('{2, 2, 6});
        @(posedge clk);
        #1 reset = 1'b1;
        wait_ack("redo");
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        chk("redo_clr", 32'(clr0), 1);
        wait_done("redo");

        repeat (3) @(posedge clk);
        chk("queues_empty", resq.size() + ackq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
